// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with optional iterative M-extension (macro ALU_M_EXT_EN)
module alu_exec_unit #(
  parameter int unsigned XLEN = 32,
  localparam int unsigned SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [6:0]      op_code,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            illegal
);

  typedef enum logic [1:0] {
`ifdef ALU_M_EXT_EN
    BUSY = 2'd2,
`endif
    IDLE = 2'd0,
    HOLD = 2'd1
  } state_e;

  state_e          state_q;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic            branch_q;
  logic            illegal_q;

  logic                   accept;
  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic [XLEN-1:0]        sum;
  logic [XLEN-1:0]        diff;
  logic [SHW-1:0]         shamt;
  logic [XLEN-1:0]        sc_result;
  logic                   sc_branch;
  logic                   sc_illegal;
  logic                   is_m;
  logic                   unused_opcode;

  assign unused_opcode = ^{op_code[6], op_code[4:0]};

  assign a_s   = op_a;
  assign b_s   = op_b;
  assign sum   = op_a + op_b;
  assign diff  = op_a - op_b;
  assign shamt = op_b[SHW-1:0];

  // Flush blocks acceptance; HOLD can take a new op in the cycle its result drains.
  assign in_ready = !flush && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
  assign accept   = in_valid && in_ready;

  // Single-cycle decode and compute, plus illegal-encoding and M-op detection.
  always_comb begin
    sc_result  = '0;
    sc_branch  = 1'b0;
    sc_illegal = 1'b0;
    is_m       = 1'b0;
    case (alu_op)
      2'b00: sc_result = sum;
      2'b10: begin
        if (op_code[5] && (funct7 == 7'b0000001)) begin
`ifdef ALU_M_EXT_EN
          is_m = 1'b1;
`else
          sc_illegal = 1'b1;
`endif
        end else begin
          case (funct3)
            3'b000: sc_result = (op_code[5] && funct7[5]) ? diff : sum;
            3'b001: sc_result = op_a << shamt;
            3'b010: sc_result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            3'b011: sc_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            3'b100: sc_result = op_a ^ op_b;
            3'b101: sc_result = funct7[5] ? XLEN'(a_s >>> shamt) : (op_a >> shamt);
            3'b110: sc_result = op_a | op_b;
            default: sc_result = op_a & op_b;
          endcase
        end
      end
      2'b01: begin
        sc_result = diff;
        case (funct3)
          3'b000: sc_branch = (op_a == op_b);
          3'b001: sc_branch = (op_a != op_b);
          3'b100: sc_branch = (a_s < b_s);
          3'b101: sc_branch = (a_s >= b_s);
          3'b110: sc_branch = (op_a < op_b);
          3'b111: sc_branch = (op_a >= op_b);
          default: begin
            sc_illegal = 1'b1;
            sc_result  = '0;
          end
        endcase
      end
      default: sc_illegal = 1'b1;
    endcase
  end

`ifdef ALU_M_EXT_EN
  localparam logic [SHW:0]    CNT_LAST = (SHW+1)'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic              m_a_signed;
  logic              m_b_signed;
  logic              m_sa;
  logic              m_sb;
  logic [XLEN-1:0]   m_mag_a;
  logic [XLEN-1:0]   m_mag_b;
  logic              m_div_zero;
  logic              m_div_ovf;
  logic              m_fast;
  logic [XLEN-1:0]   m_fast_result;

  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_d;
  logic [2*XLEN-1:0] mcand_q;
  logic [XLEN-1:0]   opb_q;
  logic [SHW:0]      cnt_q;
  logic [2:0]        f3_q;
  logic              neg_q;
  logic              rneg_q;

  logic [XLEN:0]     r_shift;
  logic [XLEN:0]     r_sub;
  logic              r_ge;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   m_result_d;
  logic              unused_rsub;

  assign unused_rsub = r_sub[XLEN];

  // Operand sign handling and the divide corner cases that bypass the sequencer.
  always_comb begin
    m_a_signed    = funct3[2] ? !funct3[0] : ((funct3 == 3'b001) || (funct3 == 3'b010));
    m_b_signed    = funct3[2] ? !funct3[0] : (funct3 == 3'b001);
    m_sa          = m_a_signed && op_a[XLEN-1];
    m_sb          = m_b_signed && op_b[XLEN-1];
    m_mag_a       = m_sa ? (-op_a) : op_a;
    m_mag_b       = m_sb ? (-op_b) : op_b;
    m_div_zero    = funct3[2] && (op_b == '0);
    m_div_ovf     = funct3[2] && !funct3[0] && (op_a == MOST_NEG) && (op_b == '1);
    m_fast        = m_div_zero || m_div_ovf;
    m_fast_result = '0;
    if (m_div_zero) begin
      m_fast_result = funct3[1] ? op_a : '1;
    end else if (m_div_ovf) begin
      m_fast_result = funct3[1] ? '0 : op_a;
    end
  end

  // One shift-add or restoring-divide step, and the sign-corrected final result.
  always_comb begin
    r_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    r_ge    = (r_shift >= {1'b0, opb_q});
    r_sub   = r_ge ? (r_shift - {1'b0, opb_q}) : r_shift;
    if (f3_q[2]) begin
      acc_d = {r_sub[XLEN-1:0], acc_q[XLEN-2:0], r_ge};
    end else begin
      acc_d = opb_q[0] ? (acc_q + mcand_q) : acc_q;
    end
    prod    = neg_q ? (-acc_d) : acc_d;
    quo_fix = neg_q ? (-acc_d[XLEN-1:0]) : acc_d[XLEN-1:0];
    rem_fix = rneg_q ? (-acc_d[2*XLEN-1:XLEN]) : acc_d[2*XLEN-1:XLEN];
    if (f3_q[2]) begin
      m_result_d = f3_q[1] ? rem_fix : quo_fix;
    end else begin
      m_result_d = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end
`endif

  // Control FSM with registered result outputs and the iterative sequencer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      branch_q    <= 1'b0;
      illegal_q   <= 1'b0;
`ifdef ALU_M_EXT_EN
      acc_q       <= '0;
      mcand_q     <= '0;
      opb_q       <= '0;
      cnt_q       <= '0;
      f3_q        <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
`endif
    end else if (flush) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (accept) begin
`ifdef ALU_M_EXT_EN
            if (is_m && !m_fast) begin
              state_q     <= BUSY;
              out_valid_q <= 1'b0;
              acc_q       <= funct3[2] ? {{XLEN{1'b0}}, m_mag_a} : '0;
              mcand_q     <= {{XLEN{1'b0}}, m_mag_a};
              opb_q       <= m_mag_b;
              neg_q       <= m_sa ^ m_sb;
              rneg_q      <= m_sa;
              f3_q        <= funct3;
              cnt_q       <= '0;
            end else begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
              result_q    <= is_m ? m_fast_result : sc_result;
              branch_q    <= sc_branch;
              illegal_q   <= sc_illegal;
            end
`else
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            result_q    <= sc_result;
            branch_q    <= sc_branch;
            illegal_q   <= sc_illegal;
`endif
          end else if ((state_q == HOLD) && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
`ifdef ALU_M_EXT_EN
        BUSY: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (!f3_q[2]) begin
            mcand_q <= mcand_q << 1;
            opb_q   <= opb_q >> 1;
          end
          if (cnt_q == CNT_LAST) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            result_q    <= m_result_d;
            branch_q    <= 1'b0;
            illegal_q   <= 1'b0;
          end
        end
`endif
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign branch_taken = branch_q;
  assign illegal      = illegal_q;

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execute-stage ALU for the RISC-V core: decodes `alu_op`/`funct3`/`funct7`/`op_code[5]` internally and computes the result, so the separate decode step is no longer needed. Single-cycle integer ops complete in one cycle. Optional M-extension multiply/divide runs as an iterative multi-cycle sequencer. It sits between the ID/EX pipeline register and EX/MEM, with a valid/ready handshake on each side and a flush input.

## Interface
- `XLEN`, 32, datapath width; power of two, 8 to 64.
- `SHW`, `$clog2(XLEN)`, shift-amount width; derived, not overridden.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  unit accepts operation this cycle.
- `alu_op`  in  2  00 add (load/store/lui/auipc/jal/jalr), 10 R/I arithmetic, 01 branch compare, 11 reserved.
- `funct3`  in  3  instruction funct3.
- `funct7`  in  7  instruction funct7 (zero for I-type except shifts).
- `op_code`  in  7  opcode; only bit 5 (R-type) used.
- `op_a`, `op_b`  in  XLEN  operands.
- `flush`  in  1  synchronous pipeline kill.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  downstream consumes result.
- `result`  out  XLEN  registered result.
- `branch_taken`  out  1  registered branch outcome (alu_op 01 only, else 0).
- `illegal`  out  1  registered illegal-encoding flag.

## Operation
- FSM states: IDLE, BUSY (iterative M op), HOLD (result waiting for `out_ready`).
- `in_ready` = (state==IDLE) or (state==HOLD and `out_ready`); deasserted while `flush`.
- An operation is accepted when `in_valid && in_ready && !flush`.
- alu_op 00: `op_a + op_b`.
- alu_op 10, funct3 decode:
  - 000: add, or sub when `op_code[5] && funct7[5]`.
  - 001: sll.
  - 010: slt, signed.
  - 011: sltu.
  - 100: xor.
  - 101: srl, or sra when `funct7[5]`.
  - 110: or.
  - 111: and.
  - Shift amount is `op_b[SHW-1:0]`.
- alu_op 01, funct3 decode: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu.
  - `result` = `op_a - op_b`.
  - funct3 010/011 is illegal.
- alu_op 11: illegal.
- Any illegal encoding sets `illegal`=1, `result`=0, `branch_taken`=0, latency 1.
- M ops (macro on): alu_op 10, `op_code[5]`=1, `funct7`=0000001; funct3 000–011 mul/mulh/mulhsu/mulhu, 100–111 div/divu/rem/remu.
  - Multiply: shift-add, one bit per cycle, 2·XLEN-bit product; high/low half selected by funct3; operand sign handling per funct3.
  - Divide: restoring, one quotient bit per cycle on magnitudes, sign fixed in the final cycle.
  - Divide by zero: quotient all-ones, remainder = `op_a`; 1-cycle latency, no BUSY.
  - Signed overflow (most-negative ÷ −1): quotient = `op_a`, remainder 0; 1-cycle latency.
- `flush`: from any state, next state IDLE and `out_valid`=0; BUSY iteration discarded. Flush wins over a simultaneous accept and over `out_ready`.
- Outputs are stable while `out_valid && !out_ready`.

## Timing
- Reset: state IDLE, `out_valid`=0, `result`=0, `branch_taken`=0, `illegal`=0. Internal counter and accumulators are cleared.
- Single-cycle op accepted at edge N: `out_valid`=1 after edge N+1.
- Iterative M op accepted at edge N: BUSY for XLEN cycles; `out_valid`=1 after edge N+XLEN+1.
- Back-to-back: in HOLD with `out_ready`=1, a new op is accepted in the same cycle, giving throughput of 1 per cycle for single-cycle ops.
- Reset asserted mid-BUSY: immediate return to reset values, no partial result.
- Iteration counter is SHW+1 bits; terminates at XLEN with no wrap.

## Configuration
- `ALU_M_EXT_EN` defined: M-extension sequencer and BUSY state compiled in.
- `ALU_M_EXT_EN` undefined: `funct7`=0000001 with alu_op 10 and `op_code[5]`=1 is illegal (1-cycle, `illegal`=1, `result`=0); BUSY is unreachable and removed.

## Test plan
- Reset then alu_op 10, `op_code[5]`=1, funct7=0100000, funct3 000, a=5, b=7 -> `result`=0xFFFFFFFE one cycle later; with `op_code[5]`=0 -> 12.
- funct3 101, funct7[5]=1, a=0x80000000, b=0x24 -> sra by 4 = 0xF8000000; funct7[5]=0 -> 0x08000000.
- alu_op 01, funct3 100, a=0xFFFFFFFF, b=1 -> `branch_taken`=1; funct3 110, same operands -> 0; funct3 010 -> `illegal`=1.
- M on: div a=−7, b=2 -> −3 after 33 cycles; rem -> −1; divu b=0 -> 0xFFFFFFFF at latency 1; div 0x80000000 ÷ −1 -> 0x80000000.
- mulhu a=b=0xFFFFFFFF -> 0xFFFFFFFE. Hold `out_ready`=0 for 5 cycles -> `result` stable and `in_ready`=0 throughout.
- Assert `flush` at BUSY cycle 10 with `in_valid`=1 -> no accept, `out_valid` stays 0, IDLE next cycle; then add 1+1 -> 2.
